// File: rtl/tank_sprite_scheduler.sv
// Multi-tank sprite scheduler: on each frame_tick, erases and redraws every tank whose
// snapshot differs from what is on screen, one clipped pixel per cycle.
module tank_sprite_scheduler #(
    parameter int NUM_TANKS     = 4,
    parameter int SPRITE        = 8,
    parameter int XW            = 8,
    parameter int YW            = 7,
    parameter int COLW          = 3,
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int BG_COLOUR     = 0,
    parameter int BARREL_COLOUR = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_TANKS*XW-1:0]   tank_x,
    input  logic [NUM_TANKS*YW-1:0]   tank_y,
    input  logic [NUM_TANKS*2-1:0]    tank_dir,
    input  logic [NUM_TANKS-1:0]      tank_alive,
    input  logic [NUM_TANKS*COLW-1:0] tank_colour,
    output logic                      busy,
    output logic                      done,
    output logic [XW-1:0]             x,
    output logic [YW-1:0]             y,
    output logic [COLW-1:0]           colour,
    output logic                      plot
);

    localparam int IW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int CW = $clog2(SPRITE);
    localparam logic [CW-1:0] LAST = CW'(SPRITE - 1);
    localparam logic [CW-1:0] MID  = CW'(SPRITE / 2);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ERASE, S_DRAW, S_NEXT, S_DONE} state_t;

    state_t r_state, w_next;

    logic [XW-1:0]   r_snap_x   [NUM_TANKS];
    logic [YW-1:0]   r_snap_y   [NUM_TANKS];
    logic [1:0]      r_snap_dir [NUM_TANKS];
    logic [COLW-1:0] r_snap_col [NUM_TANKS];
    logic [NUM_TANKS-1:0] r_snap_alive;
    logic [XW-1:0]   r_rec_x    [NUM_TANKS];
    logic [YW-1:0]   r_rec_y    [NUM_TANKS];
    logic [1:0]      r_rec_dir  [NUM_TANKS];
    logic [NUM_TANKS-1:0] r_rec_alive, r_rec_drawn;

    logic            r_force_all, r_busy, r_done, r_plot;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_row, r_col;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [COLW-1:0] r_colour;

    logic [XW-1:0]   w_sx, w_base_x;
    logic [YW-1:0]   w_sy, w_base_y;
    logic [1:0]      w_sdir;
    logic [COLW-1:0] w_scol, w_pix_colour;
    logic            w_salive, w_changed, w_last_pix, w_pixel_state, w_in_view, w_barrel;
    logic [XW:0]     w_sum_x;
    logic [YW:0]     w_sum_y;

    assign w_sx     = r_snap_x[r_idx];
    assign w_sy     = r_snap_y[r_idx];
    assign w_sdir   = r_snap_dir[r_idx];
    assign w_scol   = r_snap_col[r_idx];
    assign w_salive = r_snap_alive[r_idx];

    assign w_changed = r_force_all
                     | (w_salive != r_rec_alive[r_idx])
                     | (w_salive & ((w_sx != r_rec_x[r_idx]) | (w_sy != r_rec_y[r_idx])
                                    | (w_sdir != r_rec_dir[r_idx])));

    assign w_last_pix    = (r_row == LAST) && (r_col == LAST);
    assign w_pixel_state = (r_state == S_ERASE) || (r_state == S_DRAW);

    // Erase walks the recorded footprint, draw walks the snapshot position.
    assign w_base_x  = (r_state == S_ERASE) ? r_rec_x[r_idx] : w_sx;
    assign w_base_y  = (r_state == S_ERASE) ? r_rec_y[r_idx] : w_sy;
    assign w_sum_x   = {1'b0, w_base_x} + (XW+1)'(r_col);
    assign w_sum_y   = {1'b0, w_base_y} + (YW+1)'(r_row);
    assign w_in_view = (w_sum_x < (XW+1)'(SCREEN_W)) && (w_sum_y < (YW+1)'(SCREEN_H));

    // Barrel ray from the sprite centre in the facing direction
    always_comb begin
        w_barrel = 1'b0;
        case (w_sdir)
            2'b00:   w_barrel = (r_col == MID) && (r_row < MID);
            2'b01:   w_barrel = (r_row == MID) && (r_col > MID);
            2'b10:   w_barrel = (r_col == MID) && (r_row > MID);
            2'b11:   w_barrel = (r_row == MID) && (r_col < MID);
            default: w_barrel = 1'b0;
        endcase
    end

    // Pixel colour selection
    always_comb begin
        w_pix_colour = COLW'(BG_COLOUR);
        if (r_state == S_ERASE) begin
            w_pix_colour = COLW'(BG_COLOUR);
        end else if (w_barrel) begin
            w_pix_colour = COLW'(BARREL_COLOUR);
        end else begin
            w_pix_colour = w_scol;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_tick) w_next = S_SCAN;
                else            w_next = S_IDLE;
            end
            S_SCAN: begin
                if (w_changed && r_rec_drawn[r_idx]) w_next = S_ERASE;
                else if (w_changed && w_salive)      w_next = S_DRAW;
                else                                 w_next = S_NEXT;
            end
            S_ERASE: begin
                if (w_last_pix) w_next = w_salive ? S_DRAW : S_NEXT;
                else            w_next = S_ERASE;
            end
            S_DRAW: begin
                if (w_last_pix) w_next = S_NEXT;
                else            w_next = S_DRAW;
            end
            S_NEXT: begin
                if (r_idx == IW'(NUM_TANKS - 1)) w_next = S_DONE;
                else                             w_next = S_SCAN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Snapshot, on-screen records, pixel counters and registered pixel port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_idx        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_force_all  <= 1'b1;
            r_snap_alive <= '0;
            r_rec_alive  <= '0;
            r_rec_drawn  <= '0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                r_snap_x[i]   <= '0;
                r_snap_y[i]   <= '0;
                r_snap_dir[i] <= '0;
                r_snap_col[i] <= '0;
                r_rec_x[i]    <= '0;
                r_rec_y[i]    <= '0;
                r_rec_dir[i]  <= '0;
            end
        end else begin
            r_done <= (r_state == S_DONE);
            r_plot <= w_pixel_state && w_in_view;
            if (w_pixel_state) begin
                r_x      <= w_sum_x[XW-1:0];
                r_y      <= w_sum_y[YW-1:0];
                r_colour <= w_pix_colour;
            end else begin
                r_x      <= r_x;
                r_y      <= r_y;
                r_colour <= r_colour;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_busy       <= 1'b1;
                        r_idx        <= '0;
                        r_snap_alive <= tank_alive;
                        for (int i = 0; i < NUM_TANKS; i++) begin
                            r_snap_x[i]   <= tank_x[i*XW +: XW];
                            r_snap_y[i]   <= tank_y[i*YW +: YW];
                            r_snap_dir[i] <= tank_dir[i*2 +: 2];
                            r_snap_col[i] <= tank_colour[i*COLW +: COLW];
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (r_col == LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                S_NEXT: begin
                    r_rec_x[r_idx]     <= w_sx;
                    r_rec_y[r_idx]     <= w_sy;
                    r_rec_dir[r_idx]   <= w_sdir;
                    r_rec_alive[r_idx] <= w_salive;
                    r_rec_drawn[r_idx] <= w_salive;
                    r_idx              <= r_idx + IW'(1);
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_force_all <= 1'b0;
                end
                default: begin
                    r_busy <= r_busy;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign plot   = r_plot;
    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Bench for tank_sprite_scheduler: directed vector table, hand-written corner sequences and
// random frames, all checked against a frame-level pixel-list model.
module tb_tank_sprite_scheduler;

    localparam int NT = 4, XW = 8, YW = 7, COLW = 3, S = 8, SW = 160, SH = 120;

    logic                 clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic [NT*XW-1:0]     tank_x = '0;
    logic [NT*YW-1:0]     tank_y = '0;
    logic [NT*2-1:0]      tank_dir = '0;
    logic [NT-1:0]        tank_alive = '0;
    logic [NT*COLW-1:0]   tank_colour = '0;
    logic                 busy, done, plot;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [COLW-1:0]      colour;

    tank_sprite_scheduler #(
        .NUM_TANKS(NT), .SPRITE(S), .XW(XW), .YW(YW), .COLW(COLW),
        .SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOUR(0), .BARREL_COLOUR(7)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
        .tank_alive(tank_alive), .tank_colour(tank_colour),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0]   px;
        logic [YW-1:0]   py;
        logic [COLW-1:0] pc;
    } pix_t;

    typedef struct {
        logic [NT*XW-1:0]   tx;
        logic [NT*YW-1:0]   ty;
        logic [NT*2-1:0]    td;
        logic [NT-1:0]      ta;
        logic [NT*COLW-1:0] tc;
        int plots; int lat; int fx; int fy; int fc;
    } vec_t;

    localparam logic [NT*XW-1:0]   TX0 = {8'd129, 8'd21, 8'd129, 8'd21};
    localparam logic [NT*XW-1:0]   TX2 = {8'd129, 8'd22, 8'd129, 8'd21};
    localparam logic [NT*YW-1:0]   TY  = {7'd109, 7'd109, 7'd1, 7'd1};
    localparam logic [NT*COLW-1:0] TC  = {3'd4, 3'd3, 3'd2, 3'd1};

    pix_t got_q[$], exp_q[$];
    vec_t vt [6];
    int   tests = 0, fails = 0;

    // What the model believes is on screen
    int   m_x[NT], m_y[NT], m_dir[NT];
    bit   m_alive[NT], m_drawn[NT], m_force;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_alive[i] = 0; m_drawn[i] = 0;
        end
        m_force = 1'b1;
    endtask

    function automatic bit is_barrel(input int dir, input int c, input int r);
        int dx, dy, dc, dr;
        case (dir)
            0:       begin dx = 0;  dy = -1; end
            1:       begin dx = 1;  dy = 0;  end
            2:       begin dx = 0;  dy = 1;  end
            default: begin dx = -1; dy = 0;  end
        endcase
        dc = c - S / 2;
        dr = r - S / 2;
        return ((dx == 0) ? (dc == 0) : (dc * dx > 0)) && ((dy == 0) ? (dr == 0) : (dr * dy > 0));
    endfunction

    task automatic add_square(input int bx, input int by, input int dir, input int body, input bit erase);
        pix_t p;
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S; c++) begin
                if (bx + c < SW && by + r < SH) begin
                    p.px = XW'(bx + c);
                    p.py = YW'(by + r);
                    p.pc = erase ? COLW'(0) : (is_barrel(dir, c, r) ? COLW'(7) : COLW'(body));
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Expected pixel list and inclusive tick-to-done latency for the current inputs
    task automatic model_pass(output int lat);
        int sx, sy, sd, sc;
        bit sa, chg;
        exp_q.delete();
        lat = 3 + 2 * NT;
        for (int i = 0; i < NT; i++) begin
            sx = int'(tank_x[i*XW +: XW]);
            sy = int'(tank_y[i*YW +: YW]);
            sd = int'(tank_dir[i*2 +: 2]);
            sc = int'(tank_colour[i*COLW +: COLW]);
            sa = tank_alive[i];
            chg = m_force || (sa != m_alive[i]) ||
                  (sa && (sx != m_x[i] || sy != m_y[i] || sd != m_dir[i]));
            if (chg && m_drawn[i]) begin
                add_square(m_x[i], m_y[i], 0, 0, 1'b1);
                lat += S * S;
            end
            if (chg && sa) begin
                add_square(sx, sy, sd, sc, 1'b0);
                lat += S * S;
            end
            m_x[i] = sx; m_y[i] = sy; m_dir[i] = sd; m_alive[i] = sa; m_drawn[i] = sa;
        end
        m_force = 1'b0;
    endtask

    // Latency counts the tick cycle as 1 and ends on the first cycle done is high
    task automatic run_pass(input bit spam, output int lat);
        got_q.delete();
        frame_tick = 1'b1;
        lat = 1;
        @(posedge clk); #1;
        lat = 2;
        frame_tick = spam;
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (plot) got_q.push_back(pix_t'{x, y, colour});
            if (done) break;
            if (spam) frame_tick = 1'($urandom_range(0, 1));
        end
        frame_tick = 1'b0;
        check("done_within_bound", int'(done), 1);
    endtask

    task automatic check_pass(input string name, input int lat, input int exp_lat);
        int bad = -1, n;
        check({name, "_plots"}, got_q.size(), exp_q.size());
        check({name, "_latency"}, lat, exp_lat);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
        end
        if (bad < 0 && got_q.size() != exp_q.size()) bad = n;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_stream: first difference at pixel %0d got %h expected %h", name, bad,
                     (bad < got_q.size()) ? got_q[bad] : 18'h0, (bad < exp_q.size()) ? exp_q[bad] : 18'h0);
        end
    endtask

    function automatic int find_col(input int fx, input int fy);
        foreach (got_q[i]) begin
            if (int'(got_q[i].px) == fx && int'(got_q[i].py) == fy) return int'(got_q[i].pc);
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int lat, mlat, bad, cnt;

        vt[0] = '{TX0, TY, 8'h00, 4'hF, TC, 256, 267, 21, 1, 1};
        vt[1] = '{TX0, TY, 8'h00, 4'hF, TC, 0, 11, 0, 0, 0};
        vt[2] = '{TX2, TY, 8'h00, 4'hF, TC, 128, 139, 21, 109, 0};
        vt[3] = '{TX2, TY, 8'h00, 4'hD, TC, 64, 75, 129, 1, 0};
        vt[4] = '{TX2, TY, 8'h00, 4'hF, TC, 64, 75, 129, 1, 2};
        vt[5] = '{TX2, TY, 8'h01, 4'hF, TC, 128, 139, 21, 1, 0};

        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || done || plot || x != 0 || y != 0 || colour != 0) bad++;
        end
        check("idle_after_reset_nonzero_cycles", bad, 0);

        for (int v = 0; v < 6; v++) begin
            tank_x = vt[v].tx; tank_y = vt[v].ty; tank_dir = vt[v].td;
            tank_alive = vt[v].ta; tank_colour = vt[v].tc;
            model_pass(mlat);
            run_pass(1'b0, lat);
            check_pass($sformatf("vec%0d", v), lat, mlat);
            check($sformatf("vec%0d_table_plots", v), got_q.size(), vt[v].plots);
            check($sformatf("vec%0d_table_latency", v), lat, vt[v].lat);
            if (vt[v].plots > 0) begin
                if (got_q.size() > 0) begin
                    check($sformatf("vec%0d_first_x", v), int'(got_q[0].px), vt[v].fx);
                    check($sformatf("vec%0d_first_y", v), int'(got_q[0].py), vt[v].fy);
                    check($sformatf("vec%0d_first_colour", v), int'(got_q[0].pc), vt[v].fc);
                end else begin
                    check($sformatf("vec%0d_first_present", v), 0, 1);
                end
            end
            if (v == 0) begin
                check("barrel_25_1", find_col(25, 1), 7);
                check("barrel_25_4", find_col(25, 4), 7);
                check("centre_25_5_body", find_col(25, 5), 1);
            end
        end

        // frame_tick hammered during a pass must neither extend nor restart it
        model_pass(mlat);
        run_pass(1'b1, lat);
        check_pass("ignore_tick", lat, mlat);
        check("ignore_tick_latency", lat, 11);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy || done || plot) bad++;
        end
        check("no_restart_after_spam", bad, 0);

        // Reset in the middle of tank0's draw
        do_reset();
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("plot_before_midreset", int'(plot), 1);
        #3 reset = 1'b1;
        #1;
        check("plot_during_reset", int'(plot), 0);
        check("busy_during_reset", int'(busy), 0);
        model_reset();
        #2 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy || plot || done) bad++;
        end
        check("quiet_after_midreset", bad, 0);
        model_pass(mlat);
        run_pass(1'b0, lat);
        check_pass("redraw_after_reset", lat, mlat);
        check("redraw_after_reset_count", got_q.size(), 256);

        // Clipping at the bottom-right corner
        do_reset();
        tank_x[0 +: XW] = 8'd156;
        tank_y[0 +: YW] = 7'd116;
        model_pass(mlat);
        run_pass(1'b0, lat);
        check_pass("clip", lat, mlat);
        cnt = 0;
        foreach (got_q[i]) if (got_q[i].px >= 8'd156) cnt++;
        check("clip_tank0_visible", cnt, 16);
        check("clip_latency", lat, 267);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    tank_x[i*XW +: XW]        = XW'($urandom_range(0, 255));
                    tank_y[i*YW +: YW]        = YW'($urandom_range(0, 127));
                    tank_dir[i*2 +: 2]        = 2'($urandom_range(0, 3));
                    tank_colour[i*COLW +: COLW] = COLW'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 3) == 0) tank_alive[i] = ~tank_alive[i];
            end
            model_pass(mlat);
            run_pass(1'b0, lat);
            check_pass($sformatf("rand%0d", n), lat, mlat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
